spi_wb_xfer_ctrl: RTL and testbench
===================================

Name: spi_wb_xfer_ctrl

Overview:
- Wishbone master sequencer that drives the 8-bit Wishbone slave port of the SPI master core: registers at 0 SPCR, 1 SPSR, 2 SPDR, 3 SPER, 4 SS.
- Accepts a transfer command plus a byte stream, then programs the core and asserts slave select.
- Pushes each TX byte, polls for received data and returns RX bytes, then deasserts slave select.
- Sits between a local requester (DMA/test sequencer) and the SPI core, replacing CPU-driven register access.

Parameters:
- LEN_W, 8, width of cmd_len_i; transfer length is cmd_len_i+1 bytes (1..2^LEN_W).
- POLL_MAX, 1023, maximum SPSR reads per byte before timeout.
- POLL_W, 10, width of the poll counter; must satisfy 2^POLL_W > POLL_MAX.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when cmd_valid_i and cmd_ready_o are both high
- cmd_len_i  in  LEN_W  byte count minus 1
- cmd_ss_i  in  2  slave-select mask, written to the SS register
- cmd_cpol_i  in  1  SPCR.CPOL
- cmd_cpha_i  in  1  SPCR.CPHA
- cmd_div_i  in  4  {ESPR[1:0], SPR[1:0]}
- tx_valid_i  in  1  TX byte valid
- tx_ready_o  out  1  TX byte taken
- tx_data_i  in  8  TX byte
- rx_valid_o  out  1  one-cycle pulse; RX byte valid
- rx_data_o  out  8  RX byte
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle pulse at end of transfer
- err_o  out  1  sticky timeout flag; cleared on next command accept
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_adr_o  out  3  Wishbone address
- wb_we_o  out  1  Wishbone write enable
- wb_dat_o  out  8  Wishbone write data
- wb_dat_i  in  8  Wishbone read data
- wb_ack_i  in  1  Wishbone acknowledge

Behaviour:
- Reset values (asynchronous, rst_i low): all outputs 0; cmd_ready_o=0 during reset, 1 in IDLE; rx_data_o=0; state IDLE; counters 0.
- All outputs are registered.
- Bus access rules:
  - Classic single access. cyc_o=stb_o=1 with adr/we/dat stable until the first cycle wb_ack_i=1.
  - cyc/stb drop in the cycle after ack; at least one idle cycle between accesses.
  - wb_dat_i is sampled on the ack cycle.
  - No access completes without ack; there is no bus timeout.
- FSM states and transitions:
  - IDLE: cmd_ready_o=1. On accept, latch all cmd fields, set remaining count to cmd_len_i, clear err_o, busy_o=1, go to CFG_SPCR.
  - CFG_SPCR: write addr0 = {SPIE=0, SPE=1, 0, MSTR=1, cpol, cpha, div[1:0]}.
  - CFG_SPER: write addr3 = {ICNT=00, 0000, div[3:2]}.
  - CFG_SS: write addr4 = {000000, ss}.
  - TX_WAIT: tx_ready_o=1. On tx handshake, latch the byte and go to WR_SPDR. tx_ready_o is high only in this state.
  - WR_SPDR: write addr2 = byte.
  - POLL: read addr1; on ack:
    - bit0 (RFEMPTY)=0: go to RD_SPDR;
    - else if poll count == POLL_MAX: set err_o, go to SS_OFF;
    - else increment poll count and re-read.
    - Poll count resets at each byte.
  - RD_SPDR: read addr2. On ack, drive rx_data_o = wb_dat_i and pulse rx_valid_o on the next cycle.
    - If remaining == 0, go to SS_OFF;
    - else decrement and go to TX_WAIT.
  - SS_OFF: write addr4 = 0.
  - DONE: pulse done_o for 1 cycle, busy_o=0, go to IDLE.
- Boundary conditions:
  - RX has no backpressure; the consumer must accept every pulse.
  - A timeout aborts the remaining bytes: no further tx_ready_o, SS is always released, and done_o still pulses with err_o=1.
  - cmd_ss_i=0 is legal: runs without chip select.
  - Reset mid-transfer aborts immediately; SS is not released by this block, because the core is reset by the same system reset.

Test Plan:
- Cmd len=0, ss=01, cpol=0, cpha=0, div=0000, tx=A5; slave returns 3C:
  - bus writes in order 0:0x50, 3:0x00, 4:0x01, 2:0xA5;
  - SPSR polls until RFEMPTY=0, then read 2 = 3C;
  - write 4:0x00;
  - rx_valid_o with rx_data_o=3C, then done_o, err_o=0.
- Cmd len=3, ss=10, cpol=1, cpha=1, div=0110, tx 01,02,03,04 with loopback:
  - SPCR=0x5E, SPER=0x01, SS=0x02;
  - 4 rx pulses 01..04 in order; exactly 4 SPDR writes.
- TX starvation: tx_valid_i held low 50 cycles mid-transfer -> FSM stays in TX_WAIT with no bus activity and busy_o=1; transfer resumes and completes correctly.
- Timeout: POLL_MAX=3, RFEMPTY stuck 1 -> exactly 4 SPSR reads, err_o=1, SS write 0, done_o pulse, no rx_valid_o.
- Wishbone wait states: ack delayed 0..5 random cycles -> cyc/stb/adr/dat held stable until ack; results identical to the zero-wait case.
- Reset (rst_i low) during POLL -> all outputs 0 immediately; after release cmd_ready_o=1 and a new 1-byte command completes normally.

Source files
------------

// File: rtl/spi_wb_xfer_ctrl.sv
// Wishbone master sequencer for an 8-bit SPI master core: configures the core,
// asserts slave select, streams TX bytes, polls for and returns RX bytes.
module spi_wb_xfer_ctrl #(
  parameter int LEN_W    = 8,
  parameter int POLL_MAX = 1023,
  parameter int POLL_W   = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic [1:0]       cmd_ss_i,
  input  logic             cmd_cpol_i,
  input  logic             cmd_cpha_i,
  input  logic [3:0]       cmd_div_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  input  logic [7:0]       tx_data_i,
  output logic             rx_valid_o,
  output logic [7:0]       rx_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic [2:0]       wb_adr_o,
  output logic             wb_we_o,
  output logic [7:0]       wb_dat_o,
  input  logic [7:0]       wb_dat_i,
  input  logic             wb_ack_i
);

  localparam logic [2:0] ADR_SPCR = 3'd0;
  localparam logic [2:0] ADR_SPSR = 3'd1;
  localparam logic [2:0] ADR_SPDR = 3'd2;
  localparam logic [2:0] ADR_SPER = 3'd3;
  localparam logic [2:0] ADR_SS   = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_SPCR, S_CFG_SPER, S_CFG_SS, S_TX_WAIT,
    S_WR_SPDR, S_POLL, S_RD_SPDR, S_SS_OFF, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [1:0]         ss_q, ss_d;
  logic               cpol_q, cpol_d, cpha_q, cpha_d;
  logic [3:0]         div_q, div_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic [POLL_W-1:0]  poll_q, poll_d;

  logic               cmd_ready_q, cmd_ready_d;
  logic               tx_ready_q, tx_ready_d;
  logic               rx_valid_q, rx_valid_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               cyc_q, cyc_d;
  logic [2:0]         adr_q, adr_d;
  logic               we_q, we_d;
  logic [7:0]         dat_q, dat_d;

  // Bus request raised by the current state; the shared block below turns it
  // into a classic single access with one idle cycle after every ack.
  logic               req, req_we;
  logic [2:0]         req_adr;
  logic [7:0]         req_dat;
  logic               bus_ack;

  assign bus_ack = cyc_q & wb_ack_i;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    rem_d      = rem_q;
    ss_d       = ss_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    div_d      = div_q;
    tx_byte_d  = tx_byte_q;
    poll_d     = poll_q;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data_q;
    err_d      = err_q;
    cyc_d      = cyc_q;
    adr_d      = adr_q;
    we_d       = we_q;
    dat_d      = dat_q;
    req        = 1'b0;
    req_we     = 1'b0;
    req_adr    = 3'd0;
    req_dat    = 8'h00;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          rem_d   = cmd_len_i;
          ss_d    = cmd_ss_i;
          cpol_d  = cmd_cpol_i;
          cpha_d  = cmd_cpha_i;
          div_d   = cmd_div_i;
          err_d   = 1'b0;
          state_d = S_CFG_SPCR;
        end
      end
      S_CFG_SPCR: begin
        req     = 1'b1;
        req_we  = 1'b1;
        req_adr = ADR_SPCR;
        // SPIE=0, SPE=1, MSTR=1
        req_dat = {1'b0, 1'b1, 1'b0, 1'b1, cpol_q, cpha_q, div_q[1:0]};
        if (bus_ack) state_d = S_CFG_SPER;
      end
      S_CFG_SPER: begin
        req     = 1'b1;
        req_we  = 1'b1;
        req_adr = ADR_SPER;
        req_dat = {6'b000000, div_q[3:2]};
        if (bus_ack) state_d = S_CFG_SS;
      end
      S_CFG_SS: begin
        req     = 1'b1;
        req_we  = 1'b1;
        req_adr = ADR_SS;
        req_dat = {6'b000000, ss_q};
        if (bus_ack) state_d = S_TX_WAIT;
      end
      S_TX_WAIT: begin
        if (tx_valid_i && tx_ready_q) begin
          tx_byte_d = tx_data_i;
          state_d   = S_WR_SPDR;
        end
      end
      S_WR_SPDR: begin
        req     = 1'b1;
        req_we  = 1'b1;
        req_adr = ADR_SPDR;
        req_dat = tx_byte_q;
        if (bus_ack) begin
          poll_d  = '0;
          state_d = S_POLL;
        end
      end
      S_POLL: begin
        req     = 1'b1;
        req_adr = ADR_SPSR;
        if (bus_ack) begin
          if (!wb_dat_i[0]) begin
            state_d = S_RD_SPDR;
          end else if (poll_q == POLL_W'(POLL_MAX)) begin
            err_d   = 1'b1;
            state_d = S_SS_OFF;
          end else begin
            poll_d  = poll_q + 1'b1;
          end
        end
      end
      S_RD_SPDR: begin
        req     = 1'b1;
        req_adr = ADR_SPDR;
        if (bus_ack) begin
          rx_data_d  = wb_dat_i;
          rx_valid_d = 1'b1;
          if (rem_q == '0) begin
            state_d = S_SS_OFF;
          end else begin
            rem_d   = rem_q - 1'b1;
            state_d = S_TX_WAIT;
          end
        end
      end
      S_SS_OFF: begin
        req     = 1'b1;
        req_we  = 1'b1;
        req_adr = ADR_SS;
        if (bus_ack) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (req) begin
      if (!cyc_q) begin
        cyc_d = 1'b1;
        we_d  = req_we;
        adr_d = req_adr;
        dat_d = req_dat;
      end else if (wb_ack_i) begin
        cyc_d = 1'b0;
      end
    end

    // Status outputs are registered copies of what the next state implies.
    cmd_ready_d = (state_d == S_IDLE);
    tx_ready_d  = (state_d == S_TX_WAIT);
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      ss_q        <= '0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      div_q       <= '0;
      tx_byte_q   <= '0;
      poll_q      <= '0;
      cmd_ready_q <= 1'b0;
      tx_ready_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cyc_q       <= 1'b0;
      adr_q       <= '0;
      we_q        <= 1'b0;
      dat_q       <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      ss_q        <= ss_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      div_q       <= div_d;
      tx_byte_q   <= tx_byte_d;
      poll_q      <= poll_d;
      cmd_ready_q <= cmd_ready_d;
      tx_ready_q  <= tx_ready_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cyc_q       <= cyc_d;
      adr_q       <= adr_d;
      we_q        <= we_d;
      dat_q       <= dat_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign tx_ready_o  = tx_ready_q;
  assign rx_valid_o  = rx_valid_q;
  assign rx_data_o   = rx_data_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_adr_o    = adr_q;
  assign wb_we_o     = we_q;
  assign wb_dat_o    = dat_q;

endmodule

// File: tb/tb_spi_wb_xfer_ctrl.sv
// Scoreboard bench for spi_wb_xfer_ctrl: a behavioural SPI-core slave with
// random wait states answers the bus; monitors compare against queued expectations.
module tb_spi_wb_xfer_ctrl;

  localparam int PMAX = 3;

  typedef struct packed {
    logic       we;
    logic [2:0] adr;
    logic [7:0] dat;
  } acc_t;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       cmd_valid_i, cmd_ready_o;
  logic [7:0] cmd_len_i;
  logic [1:0] cmd_ss_i;
  logic       cmd_cpol_i, cmd_cpha_i;
  logic [3:0] cmd_div_i;
  logic       tx_valid_i, tx_ready_o;
  logic [7:0] tx_data_i;
  logic       rx_valid_o;
  logic [7:0] rx_data_o;
  logic       busy_o, done_o, err_o;
  logic       wb_cyc_o, wb_stb_o, wb_we_o;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o, wb_dat_i;
  logic       wb_ack_i;

  spi_wb_xfer_ctrl #(.LEN_W(8), .POLL_MAX(PMAX), .POLL_W(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_len_i(cmd_len_i),
    .cmd_ss_i(cmd_ss_i), .cmd_cpol_i(cmd_cpol_i), .cmd_cpha_i(cmd_cpha_i),
    .cmd_div_i(cmd_div_i),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_data_i(tx_data_i),
    .rx_valid_o(rx_valid_o), .rx_data_o(rx_data_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_adr_o(wb_adr_o), .wb_we_o(wb_we_o),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  acc_t       exp_bus[$];
  logic [7:0] exp_rx[$];
  logic       exp_done[$];
  logic [7:0] tx_q[$];

  // Slave model state: 0 = loopback, 1 = fixed 0x3C reply, 2 = RFEMPTY stuck.
  int         slave_mode = 0;
  int         ws_max = 0;
  logic [7:0] slave_rxq[$];
  int         polls_left = 0;
  int         exp_polls = 0;
  int         poll_seen = 0;
  logic       poll_track = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic slave_access(input logic we, input logic [2:0] adr, input logic [7:0] dat,
                              output logic [7:0] rd);
    acc_t e;
    rd = 8'h00;
    if (poll_track && adr != 3'd1) begin
      check("poll_count", poll_seen, exp_polls);
      poll_track = 1'b0;
    end
    if (adr == 3'd1 && !we) begin
      check("spsr_read_in_poll", {31'd0, poll_track}, 32'd1);
      poll_seen++;
      rd    = 8'($urandom);
      rd[0] = (slave_mode == 2) || (polls_left > 0);
      if (polls_left > 0) polls_left--;
    end else if (exp_bus.size() == 0) begin
      check("bus_extra_access", exp_bus.size(), 1);
    end else begin
      e = exp_bus.pop_front();
      if (!e.we) check("bus_read", {we, adr}, {e.we, e.adr});
      else       check("bus_write", {we, adr, dat}, {e.we, e.adr, e.dat});
      if (we && adr == 3'd2) begin
        slave_rxq.push_back((slave_mode == 0) ? dat : 8'h3C);
        polls_left = $urandom_range(0, 2);
        exp_polls  = (slave_mode == 2) ? PMAX + 1 : polls_left + 1;
        poll_seen  = 0;
        poll_track = 1'b1;
      end
      if (!we && adr == 3'd2 && slave_rxq.size() > 0) rd = slave_rxq.pop_front();
    end
  endtask

  // Wishbone slave: random wait states, stability and idle-after-ack checks.
  initial begin : wb_slave
    logic [2:0] cap_adr;
    logic       cap_we;
    logic [7:0] cap_dat, rd;
    int         n;
    wb_ack_i = 1'b0;
    wb_dat_i = 8'h00;
    forever begin
      @(negedge clk_i);
      if (rst_i && wb_cyc_o && wb_stb_o) begin
        cap_adr = wb_adr_o;
        cap_we  = wb_we_o;
        cap_dat = wb_dat_o;
        n = $urandom_range(0, ws_max);
        for (int i = 0; i < n && rst_i; i++) begin
          @(negedge clk_i);
          if (rst_i)
            check("wb_hold", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o},
                  {2'b11, cap_we, cap_adr, cap_dat});
        end
        if (rst_i) begin
          slave_access(cap_we, cap_adr, cap_dat, rd);
          wb_dat_i = rd;
          wb_ack_i = 1'b1;
          @(negedge clk_i);
          wb_ack_i = 1'b0;
          wb_dat_i = 8'($urandom);
          if (rst_i) check("wb_idle_after_ack", {wb_cyc_o, wb_stb_o}, 2'b00);
        end
      end
    end
  end

  // Output monitor: pops the scoreboard on every rx_valid_o / done_o pulse.
  initial begin : out_mon
    forever begin
      @(negedge clk_i);
      if (rst_i && rx_valid_o) begin
        if (exp_rx.size() == 0) check("rx_unexpected", exp_rx.size(), 1);
        else                    check("rx_data", rx_data_o, exp_rx.pop_front());
      end
      if (rst_i && done_o) begin
        if (exp_done.size() == 0) check("done_unexpected", exp_done.size(), 1);
        else                      check("done_err", err_o, exp_done.pop_front());
        check("done_busy", busy_o, 0);
      end
    end
  end

  task automatic start_cmd(input int len, input logic [1:0] ss, input logic cpol,
                           input logic cpha, input logic [3:0] div, input int mode);
    int nb;
    int k;
    nb = (mode == 2) ? 1 : len + 1;
    slave_mode = mode;
    slave_rxq.delete();
    exp_bus.push_back(acc_t'{we: 1'b1, adr: 3'd0,
                             dat: 8'(8'h50 + cpol * 8 + cpha * 4 + div % 4)});
    exp_bus.push_back(acc_t'{we: 1'b1, adr: 3'd3, dat: 8'(div / 4)});
    exp_bus.push_back(acc_t'{we: 1'b1, adr: 3'd4, dat: 8'(ss)});
    for (int i = 0; i < nb; i++) begin
      exp_bus.push_back(acc_t'{we: 1'b1, adr: 3'd2, dat: tx_q[i]});
      if (mode != 2) begin
        exp_bus.push_back(acc_t'{we: 1'b0, adr: 3'd2, dat: 8'h00});
        exp_rx.push_back((mode == 0) ? tx_q[i] : 8'h3C);
      end
    end
    exp_bus.push_back(acc_t'{we: 1'b1, adr: 3'd4, dat: 8'h00});
    exp_done.push_back(mode == 2);
    cmd_len_i   = 8'(len);
    cmd_ss_i    = ss;
    cmd_cpol_i  = cpol;
    cmd_cpha_i  = cpha;
    cmd_div_i   = div;
    cmd_valid_i = 1'b1;
    k = 0;
    while (!cmd_ready_o && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    if (!cmd_ready_o) check("cmd_ready_timeout", cmd_ready_o, 1);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    tx_data_i  = b;
    tx_valid_i = 1'b1;
    k = 0;
    while (!tx_ready_o && k < 2000) begin
      @(negedge clk_i);
      k++;
    end
    if (!tx_ready_o) check("tx_ready_timeout", tx_ready_o, 1);
    @(negedge clk_i);
    tx_valid_i = 1'b0;
  endtask

  task automatic finish_cmd(input int len, input int mode, input int gap);
    int nb, k, bad;
    logic saw_ready;
    nb = (mode == 2) ? 1 : len + 1;
    for (int i = 0; i < nb; i++) begin
      if (i == gap) begin
        k = 0;
        while (!tx_ready_o && k < 2000) begin
          @(negedge clk_i);
          k++;
        end
        bad = 0;
        for (int c = 0; c < 50; c++) begin
          if (wb_cyc_o || wb_stb_o || !busy_o || !tx_ready_o) bad++;
          @(negedge clk_i);
        end
        check("starve_idle_bus", bad, 0);
      end
      send_byte(tx_q[i]);
    end
    // After a timeout the remaining bytes are offered but must never be taken.
    if (mode == 2 && len > 0) begin
      tx_data_i  = tx_q[1];
      tx_valid_i = 1'b1;
    end
    saw_ready = 1'b0;
    k = 0;
    while (!done_o && k < 5000) begin
      @(negedge clk_i);
      if (tx_ready_o) saw_ready = 1'b1;
      k++;
    end
    if (!done_o) check("done_timeout", done_o, 1);
    tx_valid_i = 1'b0;
    @(negedge clk_i);
    if (mode == 2) check("no_tx_after_timeout", saw_ready, 0);
    check("bus_left", exp_bus.size(), 0);
    check("rx_left", exp_rx.size(), 0);
    check("done_left", exp_done.size(), 0);
    @(negedge clk_i);
  endtask

  task automatic run_cmd(input int len, input logic [1:0] ss, input logic cpol,
                         input logic cpha, input logic [3:0] div, input int mode,
                         input int gap);
    start_cmd(len, ss, cpol, cpha, div, mode);
    finish_cmd(len, mode, gap);
  endtask

  function automatic logic [27:0] all_outs();
    return {cmd_ready_o, tx_ready_o, rx_valid_o, rx_data_o, busy_o, done_o, err_o,
            wb_cyc_o, wb_stb_o, wb_adr_o, wb_we_o, wb_dat_o};
  endfunction

  initial begin
    int k;
    rst_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_len_i = 8'h00; cmd_ss_i = 2'b00;
    cmd_cpol_i = 1'b0;  cmd_cpha_i = 1'b0; cmd_div_i = 4'h0;
    tx_valid_i = 1'b0;  tx_data_i = 8'h00;
    #2 rst_i = 1'b0;
    #1 check("reset_outputs", all_outs(), 0);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    check("idle_cmd_ready", {cmd_ready_o, busy_o}, 2'b10);

    // Single byte, fixed reply 0x3C, zero wait states.
    tx_q = {8'hA5};
    run_cmd(0, 2'b01, 1'b0, 1'b0, 4'b0000, 1, -1);

    // Four bytes, loopback, CPOL/CPHA set, divider 0110.
    tx_q = {8'h01, 8'h02, 8'h03, 8'h04};
    run_cmd(3, 2'b10, 1'b1, 1'b1, 4'b0110, 0, -1);

    // TX starvation before the third byte.
    tx_q = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
    run_cmd(3, 2'b11, 1'b0, 1'b1, 4'b1001, 0, 2);

    // RFEMPTY stuck: timeout on the first of three bytes.
    tx_q = {8'h11, 8'h22, 8'h33};
    run_cmd(2, 2'b01, 1'b0, 1'b0, 4'b0011, 2, -1);

    // Random commands with 0..5 wait states; err must be cleared again.
    ws_max = 5;
    for (int c = 0; c < 6; c++) begin
      int len;
      len = $urandom_range(0, 5);
      tx_q.delete();
      for (int i = 0; i <= len; i++) tx_q.push_back(8'($urandom));
      run_cmd(len, 2'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
              $urandom_range(0, 1), -1);
    end
    ws_max = 0;

    // Reset while polling, then a normal one-byte command.
    tx_q = {8'h5A};
    start_cmd(0, 2'b01, 1'b0, 1'b0, 4'b0000, 2);
    send_byte(tx_q[0]);
    k = 0;
    while (!(wb_cyc_o && wb_adr_o == 3'd1 && !wb_we_o) && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    check("reached_poll", {wb_cyc_o, wb_we_o, wb_adr_o}, {1'b1, 1'b0, 3'd1});
    #2 rst_i = 1'b0;
    #1 check("reset_mid_poll", all_outs(), 0);
    repeat (3) @(negedge clk_i);
    exp_bus.delete();
    exp_rx.delete();
    exp_done.delete();
    slave_rxq.delete();
    poll_track = 1'b0;
    polls_left = 0;
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    check("ready_after_reset", {cmd_ready_o, busy_o, err_o}, 3'b100);
    tx_q = {8'hC3};
    run_cmd(0, 2'b10, 1'b1, 1'b0, 4'b1111, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
